// File: rtl/ex_stage.sv
// Execute stage: one bundle slot (S) feeding the external ALU and one output
// register (O) toward MEM, each with its own valid bit and handshake.
module ex_stage #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned ALU_OP_W = 12,
  parameter int unsigned RD_W     = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [XLEN-1:0]     id_pc,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic [XLEN-1:0]     id_rs1,
  input  logic [XLEN-1:0]     id_rs2,
  input  logic [XLEN-1:0]     id_imm,
  input  logic                id_src1_pc,
  input  logic                id_src2_imm,
  input  logic                id_alu_32,
  input  logic [RD_W-1:0]     id_rd,
  input  logic                id_rd_we,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [XLEN-1:0]     alu_src1,
  output logic [XLEN-1:0]     alu_src2,
  output logic                alu_32,
  input  logic [XLEN-1:0]     alu_result,
  input  logic                alu_over,
  output logic                ex_valid,
  input  logic                mem_ready,
  output logic [XLEN-1:0]     ex_pc,
  output logic [XLEN-1:0]     ex_result,
  output logic [XLEN-1:0]     ex_store_data,
  output logic [RD_W-1:0]     ex_rd,
  output logic                ex_rd_we
);

  // Slot S
  logic                r_s_valid;
  logic [XLEN-1:0]     r_s_pc;
  logic [ALU_OP_W-1:0] r_s_alu_op;
  logic [XLEN-1:0]     r_s_rs1;
  logic [XLEN-1:0]     r_s_rs2;
  logic [XLEN-1:0]     r_s_imm;
  logic                r_s_src1_pc;
  logic                r_s_src2_imm;
  logic                r_s_alu_32;
  logic [RD_W-1:0]     r_s_rd;
  logic                r_s_rd_we;

  // Output register O
  logic                r_ex_valid;
  logic [XLEN-1:0]     r_ex_pc;
  logic [XLEN-1:0]     r_ex_result;
  logic [XLEN-1:0]     r_ex_store_data;
  logic [RD_W-1:0]     r_ex_rd;
  logic                r_ex_rd_we;

  logic                w_s_done;
  logic                w_advance;
  logic                w_accept;
  logic [XLEN-1:0]     w_result;

  // Handshake decisions, ALU operand selection and result shaping
  always_comb begin
    w_s_done  = r_s_valid & (alu_over | (r_s_alu_op == '0));
    w_advance = w_s_done & (~r_ex_valid | mem_ready);
    id_ready  = ~flush & (~r_s_valid | w_advance);
    w_accept  = id_valid & id_ready;

    alu_op    = r_s_valid ? r_s_alu_op : '0;
    alu_src1  = r_s_src1_pc  ? r_s_pc  : r_s_rs1;
    alu_src2  = r_s_src2_imm ? r_s_imm : r_s_rs2;
    alu_32    = r_s_alu_32;

    w_result  = alu_result;
    if (r_s_alu_op == '0) begin
      w_result = '0;
    end else if (r_s_alu_32) begin
      w_result = {{(XLEN-32){alu_result[31]}}, alu_result[31:0]};
    end
  end

  // Slot S valid: flush wins, then accept, then drain on advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_valid <= 1'b0;
    end else if (flush) begin
      r_s_valid <= 1'b0;
    end else if (w_accept) begin
      r_s_valid <= 1'b1;
    end else if (w_advance) begin
      r_s_valid <= 1'b0;
    end
  end

  // Slot S payload captured on every accepted ID bundle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_pc       <= '0;
      r_s_alu_op   <= '0;
      r_s_rs1      <= '0;
      r_s_rs2      <= '0;
      r_s_imm      <= '0;
      r_s_src1_pc  <= 1'b0;
      r_s_src2_imm <= 1'b0;
      r_s_alu_32   <= 1'b0;
      r_s_rd       <= '0;
      r_s_rd_we    <= 1'b0;
    end else if (w_accept) begin
      r_s_pc       <= id_pc;
      r_s_alu_op   <= id_alu_op;
      r_s_rs1      <= id_rs1;
      r_s_rs2      <= id_rs2;
      r_s_imm      <= id_imm;
      r_s_src1_pc  <= id_src1_pc;
      r_s_src2_imm <= id_src2_imm;
      r_s_alu_32   <= id_alu_32;
      r_s_rd       <= id_rd;
      r_s_rd_we    <= id_rd_we;
    end
  end

  // Output valid: flush wins, set on advance, cleared once MEM takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_advance) begin
      r_ex_valid <= 1'b1;
    end else if (mem_ready) begin
      r_ex_valid <= 1'b0;
    end
  end

  // Output payload only moves on advance, so it is frozen under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_pc         <= '0;
      r_ex_result     <= '0;
      r_ex_store_data <= '0;
      r_ex_rd         <= '0;
      r_ex_rd_we      <= 1'b0;
    end else if (w_advance) begin
      r_ex_pc         <= r_s_pc;
      r_ex_result     <= w_result;
      r_ex_store_data <= r_s_rs2;
      r_ex_rd         <= r_s_rd;
      r_ex_rd_we      <= r_s_rd_we;
    end
  end

  assign ex_valid      = r_ex_valid;
  assign ex_pc         = r_ex_pc;
  assign ex_result     = r_ex_result;
  assign ex_store_data = r_ex_store_data;
  assign ex_rd         = r_ex_rd;
  assign ex_rd_we      = r_ex_rd_we & r_ex_valid;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: bench-side ALU, transaction scoreboard checked on every
// MEM handshake, plus directed scenarios with literal expectations.
module tb_ex_stage;
  localparam int unsigned XLEN = 64;
  localparam int unsigned OPW  = 12;
  localparam int unsigned RDW  = 5;

  localparam logic [11:0] OP_ADD  = 12'h800;
  localparam logic [11:0] OP_SUB  = 12'h400;
  localparam logic [11:0] OP_SLT  = 12'h200;
  localparam logic [11:0] OP_SLTU = 12'h100;
  localparam logic [11:0] OP_AND  = 12'h080;
  localparam logic [11:0] OP_OR   = 12'h040;
  localparam logic [11:0] OP_XOR  = 12'h020;
  localparam logic [11:0] OP_SLL  = 12'h010;
  localparam logic [11:0] OP_SRL  = 12'h008;
  localparam logic [11:0] OP_SRA  = 12'h004;

  logic            clk = 1'b0;
  logic            rst_n, flush, id_valid, id_ready;
  logic [63:0]     id_pc, id_rs1, id_rs2, id_imm;
  logic [11:0]     id_alu_op;
  logic            id_src1_pc, id_src2_imm, id_alu_32, id_rd_we;
  logic [4:0]      id_rd;
  logic [11:0]     alu_op;
  logic [63:0]     alu_src1, alu_src2, alu_result;
  logic            alu_32, alu_over, tb_over;
  logic            ex_valid, mem_ready, ex_rd_we;
  logic [63:0]     ex_pc, ex_result, ex_store_data;
  logic [4:0]      ex_rd;

  int n_vec = 0;
  int n_err = 0;

  ex_stage #(.XLEN(XLEN), .ALU_OP_W(OPW), .RD_W(RDW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_alu_op(id_alu_op), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm(id_imm),
    .id_src1_pc(id_src1_pc), .id_src2_imm(id_src2_imm), .id_alu_32(id_alu_32),
    .id_rd(id_rd), .id_rd_we(id_rd_we),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_32(alu_32),
    .alu_result(alu_result), .alu_over(alu_over),
    .ex_valid(ex_valid), .mem_ready(mem_ready), .ex_pc(ex_pc),
    .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we)
  );

  always #5 clk = ~clk;

  // Reference ALU: raw result, no W sign extension (that is the stage's job)
  function automatic logic [63:0] alu_f(input logic [11:0] op, input logic [63:0] a,
                                        input logic [63:0] b, input logic w);
    logic [31:0] t;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return {63'b0, $signed(a) < $signed(b)};
      OP_SLTU: return {63'b0, a < b};
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return w ? (a << b[4:0]) : (a << b[5:0]);
      OP_SRL:  return w ? ({32'b0, a[31:0]} >> b[4:0]) : (a >> b[5:0]);
      OP_SRA:  begin
        if (w) begin
          t = $signed(a[31:0]) >>> b[4:0];
          return {32'b0, t};
        end
        return $signed(a) >>> b[5:0];
      end
      default: return 64'd0;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_f(alu_op, alu_src1, alu_src2, alu_32);
    alu_over   = tb_over;
  end

  typedef struct {
    logic [63:0] pc;
    logic [63:0] res;
    logic [63:0] sd;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic        hold_prev = 1'b0;
  logic [63:0] h_pc, h_res, h_sd;
  logic [4:0]  h_rd;
  logic        h_we;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  // What an accepted bundle must eventually deliver to MEM
  function automatic exp_t expect_of();
    exp_t x;
    logic [63:0] a, b, r;
    a = id_src1_pc ? id_pc : id_rs1;
    b = id_src2_imm ? id_imm : id_rs2;
    r = alu_f(id_alu_op, a, b, id_alu_32);
    if (id_alu_op == 12'd0)  x.res = 64'd0;
    else if (id_alu_32)      x.res = {{32{r[31]}}, r[31:0]};
    else                     x.res = r;
    x.pc = id_pc;
    x.sd = id_rs2;
    x.rd = id_rd;
    x.we = id_rd_we;
    return x;
  endfunction

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_pc",  ex_pc,         h_pc);
        chk("hold_res", ex_result,     h_res);
        chk("hold_sd",  ex_store_data, h_sd);
        chk("hold_rd",  {59'b0, ex_rd}, {59'b0, h_rd});
        chk("hold_we",  {63'b0, ex_rd_we}, {63'b0, h_we});
      end
      if (!ex_valid) chk("bubble_we", {63'b0, ex_rd_we}, 64'd0);
      if (ex_valid && mem_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_delivery", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("sb_pc",  ex_pc,         e.pc);
          chk("sb_res", ex_result,     e.res);
          chk("sb_sd",  ex_store_data, e.sd);
          chk("sb_rd",  {59'b0, ex_rd}, {59'b0, e.rd});
          chk("sb_we",  {63'b0, ex_rd_we}, {63'b0, e.we});
        end
      end
      hold_prev = ex_valid && !mem_ready && !flush;
      h_pc = ex_pc; h_res = ex_result; h_sd = ex_store_data; h_rd = ex_rd; h_we = ex_rd_we;
      if (flush) q.delete();
      else if (id_valid && id_ready) q.push_back(expect_of());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [11:0] op, input logic [63:0] pc, input logic [63:0] rs1,
                       input logic [63:0] rs2, input logic [63:0] imm, input logic s1pc,
                       input logic s2imm, input logic w, input logic [4:0] rd);
    id_valid = 1'b1; id_alu_op = op; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_imm = imm;
    id_src1_pc = s1pc; id_src2_imm = s2imm; id_alu_32 = w; id_rd = rd; id_rd_we = 1'b1;
  endtask

  task automatic idle();
    id_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; mem_ready = 1'b1; tb_over = 1'b1;
    id_valid = 1'b0; id_alu_op = '0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_imm = '0;
    id_src1_pc = 1'b0; id_src2_imm = 1'b0; id_alu_32 = 1'b0; id_rd = '0; id_rd_we = 1'b0;
    #2;
    chk("rst_ex_valid", {63'b0, ex_valid}, 64'd0);
    chk("rst_ex_result", ex_result, 64'd0);
    chk("rst_alu_src1", alu_src1, 64'd0);
    chk("rst_alu_op", {52'b0, alu_op}, 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // 1: add 5+7, ex_valid set by the edge after the one that accepted it
    drive(OP_ADD, 64'h40, 64'd5, 64'd7, 64'd0, 1'b0, 1'b0, 1'b0, 5'd1);
    #1 chk("t1_id_ready", {63'b0, id_ready}, 64'd1);
    step(); idle();
    chk("t1_ex_valid_early", {63'b0, ex_valid}, 64'd0);
    step();
    chk("t1_ex_valid", {63'b0, ex_valid}, 64'd1);
    chk("t1_result", ex_result, 64'd12);
    chk("t1_rd_we", {63'b0, ex_rd_we}, 64'd1);
    step();

    // 2: addw with imm, ALU slow for two cycles
    drive(OP_ADD, 64'h44, 64'h7FFF_FFFF, 64'hDEAD, 64'd1, 1'b0, 1'b1, 1'b1, 5'd2);
    step(); idle(); tb_over = 1'b0;
    #1 chk("t2_alu_src2", alu_src2, 64'd1);
    chk("t2_alu_op", {52'b0, alu_op}, {52'b0, OP_ADD});
    step(); chk("t2_retry1", {63'b0, ex_valid}, 64'd0);
    step(); chk("t2_retry2", {63'b0, ex_valid}, 64'd0);
    tb_over = 1'b1;
    step();
    chk("t2_result", ex_result, 64'hFFFF_FFFF_8000_0000);
    chk("t2_store", ex_store_data, 64'hDEAD);
    step();

    // 3: auipc
    drive(OP_ADD, 64'h8000_0000, 64'h1234, 64'd0, 64'h1000, 1'b1, 1'b1, 1'b0, 5'd3);
    step(); idle(); step();
    chk("t3_result", ex_result, 64'h8000_1000);
    chk("t3_pc", ex_pc, 64'h8000_0000);
    step();

    // 4: backpressure with three ops
    mem_ready = 1'b0;
    drive(OP_SUB, 64'h100, 64'd10, 64'd3, 64'd0, 1'b0, 1'b0, 1'b0, 5'd11);
    #1 chk("t4_rdy1", {63'b0, id_ready}, 64'd1);
    step();
    drive(OP_XOR, 64'h104, 64'hF0, 64'h0F, 64'd0, 1'b0, 1'b0, 1'b0, 5'd12);
    #1 chk("t4_rdy2", {63'b0, id_ready}, 64'd1);
    step();
    drive(OP_SRA, 64'h108, 64'h8000_0000, 64'd4, 64'd0, 1'b0, 1'b0, 1'b1, 5'd13);
    for (int unsigned i = 0; i < 4; i++) begin
      #1 chk("t4_stall_rdy", {63'b0, id_ready}, 64'd0);
      chk("t4_stall_rd", {59'b0, ex_rd}, 64'd11);
      step();
    end
    chk("t4_op1_res", ex_result, 64'd7);
    mem_ready = 1'b1;
    #1 chk("t4_rel_rdy", {63'b0, id_ready}, 64'd1);
    step(); idle();
    chk("t4_op2_rd", {59'b0, ex_rd}, 64'd12);
    step();
    chk("t4_op3_rd", {59'b0, ex_rd}, 64'd13);
    chk("t4_op3_res", ex_result, 64'hFFFF_FFFF_F800_0000);
    step();
    chk("t4_drained", {63'b0, ex_valid}, 64'd0);

    // 5: flush with S and O full and ID offering a bundle
    mem_ready = 1'b0;
    drive(OP_OR, 64'h200, 64'd1, 64'd2, 64'd0, 1'b0, 1'b0, 1'b0, 5'd21);
    step();
    drive(OP_AND, 64'h204, 64'd3, 64'd6, 64'd0, 1'b0, 1'b0, 1'b0, 5'd22);
    step();
    drive(OP_ADD, 64'h208, 64'd9, 64'd9, 64'd0, 1'b0, 1'b0, 1'b0, 5'd23);
    flush = 1'b1;
    #1 chk("t5_flush_rdy", {63'b0, id_ready}, 64'd0);
    step();
    flush = 1'b0; mem_ready = 1'b1;
    chk("t5_ex_valid", {63'b0, ex_valid}, 64'd0);
    chk("t5_alu_op", {52'b0, alu_op}, 64'd0);
    drive(OP_SLTU, 64'h20C, 64'd1, 64'd2, 64'd0, 1'b0, 1'b0, 1'b0, 5'd24);
    #1 chk("t5_resume_rdy", {63'b0, id_ready}, 64'd1);
    step(); idle(); step();
    chk("t5_resume_rd", {59'b0, ex_rd}, 64'd24);
    chk("t5_resume_res", ex_result, 64'd1);
    step();

    // 6: no-op bundle passes through with zero result
    drive(12'd0, 64'h300, 64'd5, 64'h55, 64'd7, 1'b0, 1'b0, 1'b0, 5'd4);
    step(); idle(); step();
    chk("t6_fence_valid", {63'b0, ex_valid}, 64'd1);
    chk("t6_fence_res", ex_result, 64'd0);
    chk("t6_fence_sd", ex_store_data, 64'h55);
    step();

    // 6b: async reset during a stall
    mem_ready = 1'b0;
    drive(OP_ADD, 64'h400, 64'd1, 64'd1, 64'd0, 1'b0, 1'b0, 1'b0, 5'd9);
    step();
    drive(OP_ADD, 64'h404, 64'd2, 64'd2, 64'd0, 1'b0, 1'b0, 1'b0, 5'd10);
    step(); idle();
    rst_n = 1'b0;
    #1 chk("t6_rst_valid", {63'b0, ex_valid}, 64'd0);
    chk("t6_rst_alu_op", {52'b0, alu_op}, 64'd0);
    chk("t6_rst_rd", {59'b0, ex_rd}, 64'd0);
    chk("t6_rst_rdy", {63'b0, id_ready}, 64'd1);
    step();
    rst_n = 1'b1; mem_ready = 1'b1;
    drive(OP_SLL, 64'h500, 64'd3, 64'd4, 64'd0, 1'b0, 1'b0, 1'b0, 5'd15);
    step(); idle(); step();
    chk("t6_after_rst_res", ex_result, 64'd48);
    step(); step();
    chk("sb_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
